// File: rtl/tnew_e_pkg.sv
// Shared MIPS destination-decode definitions: opcode/funct encodings, tnew
// constants and the hazard descriptor carried by the E/M/W hazard blocks.
package tnew_e_pkg;

    localparam int unsigned T_ALU      = 1;
    localparam int unsigned T_LOAD     = 2;
    localparam int unsigned TNEW_MAX_W = 8;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_SLTIU   = 6'b001011;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_COP0    = 6'b010000;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LH      = 6'b100001;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_LBU     = 6'b100100;
    localparam logic [5:0] OP_LHU     = 6'b100101;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_JALR = 6'b001001;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    localparam logic [4:0] RS_MFC0 = 5'b00000;
    localparam logic [4:0] REG_RA  = 5'd31;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_ALU,
        CLS_LOAD,
        CLS_LINK
    } dst_class_t;

    typedef struct packed {
        logic [TNEW_MAX_W-1:0] tnew;
        logic [4:0]            writereg;
        logic [31:0]           writedata;
    } dst_desc_t;

    function automatic logic is_alu_funct(input logic [5:0] funct);
        case (funct)
            FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
            FN_MFHI, FN_MFLO,
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
            FN_AND, FN_OR, FN_XOR, FN_NOR,
            FN_SLT, FN_SLTU: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tnew_e_if.sv
// Hazard-descriptor bus between the pipeline front end and the E-stage block.
interface tnew_e_if #(
    parameter int unsigned TNEW_W = 4
);
    logic              clr;
    logic              stall;
    logic [31:0]       instr;
    logic [31:0]       PC8;
    logic [TNEW_W-1:0] tnew;
    logic [4:0]        writereg;
    logic [31:0]       writedata;

    modport master (
        output clr, stall, instr, PC8,
        input  tnew, writereg, writedata
    );

    modport slave (
        input  clr, stall, instr, PC8,
        output tnew, writereg, writedata
    );
endinterface

// File: rtl/tnew_e_mips_dst_decode.sv
// Combinational map from an instruction and its PC+8 to the hazard descriptor
// (destination GPR, static tnew, immediately forwardable value).
module mips_dst_decode #(
    parameter int unsigned T_ALU  = tnew_e_pkg::T_ALU,
    parameter int unsigned T_LOAD = tnew_e_pkg::T_LOAD
) (
    input  logic [31:0]           instr,
    input  logic [31:0]           pc8,
    output tnew_e_pkg::dst_desc_t desc
);
    import tnew_e_pkg::*;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unused_shamt;

    dst_class_t cls;
    logic [4:0] dst;

    assign opcode       = instr[31:26];
    assign rs           = instr[25:21];
    assign rt           = instr[20:16];
    assign rd           = instr[15:11];
    assign funct        = instr[5:0];
    assign unused_shamt = ^instr[10:6];

    always_comb begin
        cls = CLS_NONE;
        dst = '0;
        case (opcode)
            OP_SPECIAL: begin
                if (is_alu_funct(funct)) begin
                    cls = CLS_ALU;
                    dst = rd;
                end else if (funct == FN_JALR) begin
                    cls = CLS_LINK;
                    dst = rd;
                end
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                cls = CLS_ALU;
                dst = rt;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                cls = CLS_LOAD;
                dst = rt;
            end
            OP_COP0: begin
                if (rs == RS_MFC0) begin
                    cls = CLS_LOAD;
                    dst = rt;
                end
            end
            OP_JAL: begin
                cls = CLS_LINK;
                dst = REG_RA;
            end
            default: ;
        endcase
    end

    // A $0 destination is reported as "no write" so the hazard unit never stalls on it.
    always_comb begin
        desc = '0;
        if (dst != '0) begin
            desc.writereg = dst;
            case (cls)
                CLS_ALU:  desc.tnew = TNEW_MAX_W'(T_ALU);
                CLS_LOAD: desc.tnew = TNEW_MAX_W'(T_LOAD);
                CLS_LINK: desc.writedata = pc8;
                default:  desc.writereg = '0;
            endcase
        end
    end
endmodule

// File: rtl/tnew_e.sv
// E-stage hazard descriptor register: reset > clr (bubble) > stall (hold) > load.
module tnew_e #(
    parameter int unsigned TNEW_W = 4,
    parameter int unsigned T_ALU  = tnew_e_pkg::T_ALU,
    parameter int unsigned T_LOAD = tnew_e_pkg::T_LOAD
) (
    input  logic        clk,
    input  logic        reset,
    tnew_e_if.slave     bus
);
    import tnew_e_pkg::*;

    dst_desc_t next_desc;
    dst_desc_t desc_q;

    mips_dst_decode #(
        .T_ALU  (T_ALU),
        .T_LOAD (T_LOAD)
    ) u_decode (
        .instr (bus.instr),
        .pc8   (bus.PC8),
        .desc  (next_desc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            desc_q <= '0;
        end else if (bus.clr) begin
            desc_q <= '0;
        end else if (!bus.stall) begin
            desc_q <= next_desc;
        end
    end

    assign bus.tnew      = TNEW_W'(desc_q.tnew);
    assign bus.writereg  = desc_q.writereg;
    assign bus.writedata = desc_q.writedata;
endmodule

// File: tb/tb_tnew_e.sv
// Scoreboard bench for tnew_e: driver pushes expected descriptors from a
// rule-level reference model, a negedge monitor pops and compares.
module tb_tnew_e;

    typedef struct packed {
        logic [3:0]  tnew;
        logic [4:0]  wreg;
        logic [31:0] wd;
    } exp_t;

    logic clk;
    logic reset;

    tnew_e_if #(.TNEW_W(4)) bus ();

    tnew_e #(
        .TNEW_W (4),
        .T_ALU  (1),
        .T_LOAD (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  mdl;
    int    checks = 0;
    int    errors = 0;

    // Reference: classify by instruction lists, then apply the $0 rule.
    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc8);
        exp_t       e;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        int         dst;
        int         t;
        bit         link;
        e    = '0;
        op   = i[31:26];
        rs   = i[25:21];
        rt   = i[20:16];
        rd   = i[15:11];
        fn   = i[5:0];
        dst  = 0;
        t    = 0;
        link = 0;
        if (op == 6'h00 && (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                       6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                       6'h10, 6'h12})) begin
            dst = int'(rd); t = 1;
        end else if (op == 6'h00 && fn == 6'h09) begin
            dst = int'(rd); link = 1;
        end else if (op >= 6'h08 && op <= 6'h0f) begin
            dst = int'(rt); t = 1;
        end else if ((op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) || (op == 6'h10 && rs == 5'd0)) begin
            dst = int'(rt); t = 2;
        end else if (op == 6'h03) begin
            dst = 31; link = 1;
        end
        if (dst != 0) begin
            e.wreg = 5'(dst);
            e.tnew = 4'(t);
            e.wd   = link ? pc8 : 32'd0;
        end
        return e;
    endfunction

    task automatic step(input bit r, input bit c, input bit s,
                        input logic [31:0] ins, input logic [31:0] pc8, input string name);
        reset         = r;
        bus.clr       = c;
        bus.stall     = s;
        bus.instr     = ins;
        bus.PC8       = pc8;
        if (r || c) mdl = '0;
        else if (!s) mdl = ref_decode(ins, pc8);
        exp_q.push_back(mdl);
        name_q.push_back(name);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t  e;
        string n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check({n, ".tnew"}, 32'(bus.tnew), 32'(e.tnew));
            check({n, ".writereg"}, 32'(bus.writereg), 32'(e.wreg));
            check({n, ".writedata"}, bus.writedata, e.wd);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    localparam logic [31:0] ADDU3 = 32'h00221821;
    localparam logic [31:0] LW5   = 32'h8C450004;

    logic [5:0] ops [24] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
                             6'h06, 6'h07, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d,
                             6'h0e, 6'h0f, 6'h10, 6'h20, 6'h21, 6'h23, 6'h24, 6'h2b};

    initial begin
        logic [31:0] ins;
        logic [4:0]  cop_rs [3];
        cop_rs[0] = 5'd0; cop_rs[1] = 5'd4; cop_rs[2] = 5'd16;
        mdl = '0;

        step(1, 0, 0, ADDU3, 32'h0, "reset_a");
        step(1, 0, 0, ADDU3, 32'h0, "reset_b");
        step(0, 0, 0, ADDU3, 32'h0, "addu3");
        step(0, 0, 0, LW5, 32'h0, "lw5");
        step(0, 0, 0, 32'h34070001, 32'h0, "ori7");
        step(0, 0, 0, 32'h0C000C04, 32'h00003010, "jal");
        step(0, 0, 0, 32'h00800009, 32'h00001234, "jalr0");
        step(0, 0, 0, 32'h0080F809, 32'h00005678, "jalr31");
        step(0, 0, 0, 32'h40066000, 32'h0, "mfc0");
        step(0, 0, 0, 32'hAC450000, 32'h0, "sw");
        step(0, 0, 0, 32'h10220003, 32'h0, "beq");
        step(0, 0, 0, 32'h00220018, 32'h0, "mult");
        step(0, 0, 0, 32'h40826000, 32'h0, "mtc0");
        step(0, 0, 0, 32'hFFFFFFFF, 32'h0, "unknown");
        step(0, 0, 0, ADDU3, 32'h0, "addu3_again");
        step(0, 0, 1, LW5, 32'h0, "stall_hold_a");
        step(0, 0, 1, LW5, 32'h0, "stall_hold_b");
        step(0, 1, 1, LW5, 32'h0, "clr_stall");
        step(0, 0, 0, ADDU3, 32'h0, "reload");
        step(1, 1, 0, ADDU3, 32'h0, "reset_clr");
        step(0, 0, 0, 32'h00220021, 32'h0, "addu_r0");

        for (int k = 0; k < 400; k++) begin
            int unsigned sel;
            sel = $urandom_range(0, 9);
            ins = $urandom;
            if (sel < 8) begin
                ins[31:26] = ops[$urandom_range(0, 23)];
                if (ins[31:26] == 6'h10) ins[25:21] = cop_rs[$urandom_range(0, 2)];
                if (ins[31:26] == 6'h00 && sel < 2) ins[5:0] = 6'h09;
            end
            step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 15, ins, $urandom, "random");
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
